serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer. A single 1-bit full-adder instance (ports a, b, c, sum, carry) is reused over WIDTH consecutive clock cycles to add two WIDTH-bit operands plus carry-in, LSB first.
- The block owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- It trades area for latency in front of any consumer that needs an N-bit sum.

---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer.
// A single 1-bit full adder is reused over WIDTH cycles, LSB first, to form
// {cout, sum_out} = a_in + b_in + cin. A start/busy/done handshake frames
// each operation.

// 1-bit full adder reused by the sequencer on every RUN cycle.
module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));

endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 lower sum bits; the MSB is taken straight from the
  // adder on the final RUN edge so sum_out is valid in the done cycle.
  logic [RW-1:0]    res_sh;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;

  serial_add_fa u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (c_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Sequencer: operand capture, serial shifting, result/handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            c_q    <= cin;
            cnt    <= '0;
            res_sh <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end

        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= (res_sh >> 1) | (RW'(fa_sum) << (WIDTH - 2));
          c_q    <= fa_carry;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum_out <= {fa_sum, res_sh};
            cout    <= fa_carry;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases with
// literal expectations plus 1000 random operations against a timing/arith model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start at edge k means busy after edges
  // k..k+W-1, done after edge k+W, next acceptance possible at edge k+W+2.
  int       edge_no  = 0;
  int       acc      = -1000;
  logic [W:0] pend   = '0;
  logic [W:0] held   = '0;
  logic     exp_busy = 1'b0;
  logic     exp_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_no  = 0;
      acc      = -1000;
      held     = '0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
    end else begin
      edge_no++;
      if (start && edge_no >= acc + W + 2) begin
        acc  = edge_no;
        pend = (W+1)'(a_in) + (W+1)'(b_in) + (W+1)'(cin);
      end
      exp_busy = (edge_no >= acc) && (edge_no <= acc + W - 1);
      exp_done = (edge_no == acc + W);
      if (exp_done) held = pend;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_busy", busy, exp_busy);
    chk("model_done", done, exp_done);
    if (!busy) chk("model_result", {cout, sum_out}, held);
  end

  // Issue one operation and observe it until two cycles after done.
  // mode[0]: change operands during RUN; mode[1]: re-assert start at cycles 3 and 9.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int mode, output logic [W:0] got, output int dj,
                        output int nbusy, output int ndone);
    dj = -1; nbusy = 0; ndone = 0; got = '0;
    @(negedge clk);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      start = mode[1] && (j == 2 || j == 8);
      if (mode[0] && j == 2) begin a_in = 8'h11; b_in = 8'h11; cin = 1'b0; end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (dj < 0) begin dj = j; got = {cout, sum_out}; end
      end
      if (dj >= 0 && j >= dj + 2) break;
    end
    start = 1'b0;
    if (dj < 0) chk("op_timeout_no_done", 0, 1);
  endtask

  initial begin
    logic [W:0] got;
    int dj, nb, nd;
    int d1, d2;
    logic [W:0] got2;

    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sum", sum_out, 0);
    chk("reset_cout", cout, 0);
    #2 rst = 1'b0;

    run_op(8'h00, 8'h00, 1'b0, 0, got, dj, nb, nd);
    chk("zero_done_latency", dj, 8);
    chk("zero_busy_cycles", nb, 8);
    chk("zero_result", got, 9'h000);
    chk("zero_done_count", nd, 1);

    run_op(8'hFF, 8'h01, 1'b0, 0, got, dj, nb, nd);
    chk("ff_plus_1", got, 9'h100);

    run_op(8'hA5, 8'h5A, 1'b1, 1, got, dj, nb, nd);
    chk("a5_5a_c1_scrambled", got, 9'h100);

    run_op(8'h12, 8'h34, 1'b0, 2, got, dj, nb, nd);
    chk("restart_ignored_result", got, 9'h046);
    chk("restart_ignored_done_count", nd, 1);

    // start held high: consecutive operations issue WIDTH+2 cycles apart
    d1 = -1; d2 = -1; got2 = '0;
    @(negedge clk);
    a_in = 8'h0F; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 40 && d2 < 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = i;
        else begin d2 = i; got2 = {cout, sum_out}; end
      end
    end
    start = 1'b0;
    chk("held_start_two_dones", d2 >= 0, 1);
    chk("held_start_interval", d2 - d1, W + 2);
    chk("held_start_result", got2, 9'h010);
    repeat (12) @(negedge clk);

    run_op(8'h3C, 8'h42, 1'b0, 0, got, dj, nb, nd);
    chk("3c_42", got, 9'h07E);

    // asynchronous reset in the 4th RUN cycle aborts the operation
    @(negedge clk);
    a_in = 8'hC3; b_in = 8'h7D; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum_out, 0);
    chk("abort_cout", cout, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);

    run_op(8'hC3, 8'h7D, 1'b1, 0, got, dj, nb, nd);
    chk("after_abort_result", got, 9'h141);

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      logic [W:0] sum_ref;
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      sum_ref = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), got, dj, nb, nd);
      chk("random_sum", got, sum_ref);
      chk("random_done_once", nd, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
